cpu_param: RTL and testbench



---
 rtl/cpu_param_pkg.sv | 22 ++
 rtl/cpu_param_regfile.sv | 38 +++
 rtl/cpu_param.sv | 98 +++++++++
 tb/tb_cpu_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_param_pkg.sv
// cpu_param_pkg: opcodes, shift codes, instruction field positions and FSM states for cpu_param.
package cpu_param_pkg;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;
  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;
  typedef enum logic [2:0] {WAIT, DECODE, WRIMM, GETA, GETB, ALU, WRREG, CMPST} state_t;
endpackage

// File: rtl/cpu_param_regfile.sv
// regfile_param: 8 x DW registers, synchronous write, combinational read.
module regfile_param #(parameter int DW = 16) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [2:0]    wa,
  input  logic [DW-1:0] wd,
  input  logic [2:0]    ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] R0, R1, R2, R3, R4, R5, R6, R7;
  always_ff @(posedge clk)
    if (rst) {R0, R1, R2, R3, R4, R5, R6, R7} <= '0;
    else if (we)
      case (wa)
        3'd0: R0 <= wd;
        3'd1: R1 <= wd;
        3'd2: R2 <= wd;
        3'd3: R3 <= wd;
        3'd4: R4 <= wd;
        3'd5: R5 <= wd;
        3'd6: R6 <= wd;
        3'd7: R7 <= wd;
      endcase
  always_comb begin
    rd = R0;
    case (ra)
      3'd0: rd = R0;
      3'd1: rd = R1;
      3'd2: rd = R2;
      3'd3: rd = R3;
      3'd4: rd = R4;
      3'd5: rd = R5;
      3'd6: rd = R6;
      3'd7: rd = R7;
    endcase
  end
endmodule

// File: rtl/cpu_param.sv
// cpu_param: parametrised multicycle CPU core with load/s handshake.
// Defining CPU_PARAM_CARRY_EN adds the carry flag output C, set by CMP.
module cpu_param import cpu_param_pkg::*; #(
  parameter int DW       = 16,
  parameter bit FAST_MOV = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic          load,
  input  logic [15:0]   in,
  output logic [DW-1:0] out,
  output logic          N,
  output logic          V,
  output logic          Z,
  output logic          w,
  output logic          done
`ifdef CPU_PARAM_CARRY_EN
  ,
  output logic          C
`endif
);
  state_t state, next;
  logic [15:0] ir;
  logic [DW-1:0] a, b, a_eff, rd_data, sh_b, alu, imm, diff, wr_data;
  logic [2:0] opc, rn, rd, rm, wr_addr;
  logic [1:0] op, sh;
  logic mov_imm, mov_reg, alu_op, wr_en;
  assign opc = ir[OPC_LSB +: 3];
  assign op  = ir[OP_LSB +: 2];
  assign rn  = ir[RN_LSB +: 3];
  assign rd  = ir[RD_LSB +: 3];
  assign sh  = ir[SH_LSB +: 2];
  assign rm  = ir[RM_LSB +: 3];
  assign imm = DW'($signed(ir[7:0]));
  assign mov_imm = opc == OPC_MOV && op == OP_MOVI;
  assign mov_reg = opc == OPC_MOV && op == OP_MOVR;
  assign alu_op  = opc == OPC_ALU;
  assign w = state == WAIT;
  assign sh_b = sh == SH_LSL ? {rd_data[DW-2:0], 1'b0}
              : sh == SH_LSR ? {1'b0, rd_data[DW-1:1]}
              : sh == SH_ASR ? {rd_data[DW-1], rd_data[DW-1:1]}
              : rd_data;
  // MOV-reg shares the ADD encoding, so zeroing A turns the adder into a pass-through
  assign a_eff = mov_reg ? '0 : a;
  assign alu = op == OP_AND ? a & b : op == OP_MVN ? ~b : a_eff + b;
  assign wr_en   = state == WRIMM || state == WRREG;
  assign wr_addr = state == WRIMM ? rn : rd;
  assign wr_data = state == WRIMM ? imm : out;
  if (1) begin : DP
    regfile_param #(.DW(DW)) REGFILE (
      .clk(clk), .rst(reset), .we(wr_en), .wa(wr_addr), .wd(wr_data),
      .ra(state == GETB ? rm : rn), .rd(rd_data)
    );
  end
  always_comb begin
    next = state;
    case (state)
      WAIT:    next = s ? DECODE : WAIT;
      DECODE:  next = mov_imm ? WRIMM : mov_reg ? (FAST_MOV ? GETB : GETA) : alu_op ? GETA : WAIT;
      GETA:    next = GETB;
      GETB:    next = (alu_op && op == OP_CMP) ? CMPST : ALU;
      ALU:     next = WRREG;
      default: next = WAIT;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= WAIT;
      ir <= '0;
      a <= '0;
      b <= '0;
      out <= '0;
      {N, V, Z} <= 3'b000;
      done <= 1'b0;
    end else begin
      state <= next;
      done <= state != WAIT && next == WAIT;
      if (state == WAIT && load) ir <= in;
      if (state == GETA) a <= rd_data;
      if (state == GETB) b <= sh_b;
      if (state == ALU) out <= alu;
      if (state == CMPST) begin
        N <= diff[DW-1];
        Z <= diff == '0;
        V <= (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
    end
`ifdef CPU_PARAM_CARRY_EN
  logic cout;
  assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + 1'b1;
  always_ff @(posedge clk)
    if (reset) C <= 1'b0;
    else if (state == CMPST) C <= cout;
`else
  assign diff = a - b;
`endif
endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: directed scoreboard bench for cpu_param at DW=16, DW=32 and DW=16 with FAST_MOV.
module tb_cpu_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] reset, s, load, n_f, v_f, z_f, w, done;
  logic [15:0] in_w [3];
  logic [15:0] out16, outf;
  logic [31:0] out32;
`ifdef CPU_PARAM_CARRY_EN
  logic [2:0] c_f;
`endif
  cpu_param #(.DW(16), .FAST_MOV(1'b0)) dut16 (
    .clk(clk), .reset(reset[0]), .s(s[0]), .load(load[0]), .in(in_w[0]), .out(out16),
    .N(n_f[0]), .V(v_f[0]), .Z(z_f[0]), .w(w[0]), .done(done[0])
`ifdef CPU_PARAM_CARRY_EN
    , .C(c_f[0])
`endif
  );
  cpu_param #(.DW(32), .FAST_MOV(1'b0)) dut32 (
    .clk(clk), .reset(reset[1]), .s(s[1]), .load(load[1]), .in(in_w[1]), .out(out32),
    .N(n_f[1]), .V(v_f[1]), .Z(z_f[1]), .w(w[1]), .done(done[1])
`ifdef CPU_PARAM_CARRY_EN
    , .C(c_f[1])
`endif
  );
  cpu_param #(.DW(16), .FAST_MOV(1'b1)) dutf (
    .clk(clk), .reset(reset[2]), .s(s[2]), .load(load[2]), .in(in_w[2]), .out(outf),
    .N(n_f[2]), .V(v_f[2]), .Z(z_f[2]), .w(w[2]), .done(done[2])
`ifdef CPU_PARAM_CARRY_EN
    , .C(c_f[2])
`endif
  );
  typedef struct {string tag; logic [63:0] exp;} exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  function automatic void push(string tag, logic [63:0] e);
    sb.push_back('{tag, e});
  endfunction
  function automatic void cmp(logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
    end
  endfunction
  function automatic logic [63:0] out_of(int d);
    return d == 0 ? 64'(out16) : d == 1 ? 64'(out32) : 64'(outf);
  endfunction
  task automatic exec(int d, logic [15:0] word, int exp_edges);
    int n;
    push("edges", 64'(exp_edges));
    push("done_pulse", 64'd1);
    push("done_low", 64'd0);
    @(negedge clk);
    in_w[d] = word;
    load[d] = 1'b1;
    s[d] = 1'b1;
    @(posedge clk); #1;
    load[d] = 1'b0;
    s[d] = 1'b0;
    n = 1;
    while (!w[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    cmp(64'(n));
    cmp(64'(done[d]));
    @(posedge clk); #1;
    cmp(64'(done[d]));
  endtask
  initial begin
    int n;
    reset = 3'b111;
    s = '0;
    load = '0;
    for (int i = 0; i < 3; i++) in_w[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = '0;
    for (int d = 0; d < 3; d++) begin
      push("rst_w", 64'd1);
      push("rst_done", 64'd0);
      push("rst_out", 64'd0);
      push("rst_flags", 64'd0);
      cmp(64'(w[d]));
      cmp(64'(done[d]));
      cmp(out_of(d));
      cmp(64'({z_f[d], v_f[d], n_f[d]}));
    end
    exec(0, 16'hD007, 3);
    push("r0_imm", 64'd7);
    cmp(64'(dut16.DP.REGFILE.R0));
    exec(0, 16'hD108, 3);
    push("r1_imm", 64'd8);
    cmp(64'(dut16.DP.REGFILE.R1));
    exec(0, 16'hA041, 6);
    push("add_r2", 64'd15);
    push("add_out", 64'd15);
    cmp(64'(dut16.DP.REGFILE.R2));
    cmp(out_of(0));
    exec(0, 16'hB843, 6);
    push("mvn_r2", 64'hFFFF);
    cmp(64'(dut16.DP.REGFILE.R2));
    exec(0, 16'hC092, 6);
    push("movr_lsr_r4", 64'h7FFF);
    cmp(64'(dut16.DP.REGFILE.R4));
    exec(0, 16'hAC02, 5);
    push("cmp_zvn_011", 64'b011);
    push("cmp_out_kept", 64'h7FFF);
    cmp(64'({z_f[0], v_f[0], n_f[0]}));
    cmp(out_of(0));
`ifdef CPU_PARAM_CARRY_EN
    push("cmp_c0", 64'd0);
    cmp(64'(c_f[0]));
`endif
    exec(0, 16'hAC04, 5);
    push("cmp_zvn_100", 64'b100);
    cmp(64'({z_f[0], v_f[0], n_f[0]}));
`ifdef CPU_PARAM_CARRY_EN
    push("cmp_c1", 64'd1);
    cmp(64'(c_f[0]));
`endif
    exec(0, 16'hE000, 2);
    push("ill_flags", 64'b100);
    push("ill_out", 64'h7FFF);
    push("ill_r4", 64'h7FFF);
    cmp(64'({z_f[0], v_f[0], n_f[0]}));
    cmp(out_of(0));
    cmp(64'(dut16.DP.REGFILE.R4));
    push("glitch_edges", 64'd6);
    push("glitch_done", 64'd1);
    @(negedge clk);
    in_w[0] = 16'hA0C1;
    load[0] = 1'b1;
    s[0] = 1'b1;
    @(posedge clk); #1;
    s[0] = 1'b0;
    in_w[0] = 16'hD0FF;
    n = 1;
    while (!w[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
      s[0] = n == 3;
    end
    load[0] = 1'b0;
    s[0] = 1'b0;
    cmp(64'(n));
    cmp(64'(done[0]));
    push("glitch_ir", 64'hA0C1);
    push("glitch_r6", 64'd15);
    push("glitch_r0", 64'd7);
    cmp(64'(dut16.ir));
    cmp(64'(dut16.DP.REGFILE.R6));
    cmp(64'(dut16.DP.REGFILE.R0));
    @(posedge clk); #1;
    push("glitch_idle", 64'd1);
    cmp(64'(w[0]));
    @(negedge clk);
    in_w[0] = 16'hA0A1;
    load[0] = 1'b1;
    s[0] = 1'b1;
    @(posedge clk); #1;
    load[0] = 1'b0;
    s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset[0] = 1'b1;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    push("abort_w", 64'd1);
    push("abort_r5", 64'd0);
    push("abort_out", 64'd0);
    push("abort_done", 64'd0);
    push("abort_r0", 64'd0);
    cmp(64'(w[0]));
    cmp(64'(dut16.DP.REGFILE.R5));
    cmp(out_of(0));
    cmp(64'(done[0]));
    cmp(64'(dut16.DP.REGFILE.R0));
    exec(1, 16'hD0FD, 3);
    push("w32_r0", 64'hFFFF_FFFD);
    cmp(64'(dut32.DP.REGFILE.R0));
    exec(1, 16'hD1F8, 3);
    push("w32_r1", 64'hFFFF_FFF8);
    cmp(64'(dut32.DP.REGFILE.R1));
    exec(1, 16'hC059, 6);
    push("w32_asr", 64'hFFFF_FFFC);
    cmp(64'(dut32.DP.REGFILE.R2));
    exec(1, 16'hC071, 6);
    push("w32_lsr", 64'h7FFF_FFFC);
    push("w32_out", 64'h7FFF_FFFC);
    cmp(64'(dut32.DP.REGFILE.R3));
    cmp(out_of(1));
    exec(2, 16'hD205, 3);
    exec(2, 16'hC06A, 5);
    push("fast_lsl_r3", 64'd10);
    push("fast_out", 64'd10);
    cmp(64'(dutf.DP.REGFILE.R3));
    cmp(out_of(2));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
